// File: rtl/icache_tag_sram_if.sv
// rtl/icache_tag_sram_if.sv - port bundle for the cache tag RAM
interface icache_tag_sram_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 20,
    parameter int WE_W   = 4
);
    logic              ena;
    logic [WE_W-1:0]   wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              init_done;

    modport master (
        output ena, wea, addra, dina,
        input  douta, init_done
    );

    modport slave (
        input  ena, wea, addra, dina,
        output douta, init_done
    );
endinterface

// File: rtl/icache_tag_sram.sv
// rtl/icache_tag_sram.sv - single-port tag RAM, write-first, with post-reset clear sweep
module icache_tag_sram #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 20,
    parameter int WE_W           = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clka,
    input  logic               rsta,
    icache_tag_sram_if.slave   s
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] douta_q, douta_d;
    logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic              init_done_q, init_done_d;

    logic              sweeping;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        sweeping    = (CLEAR_ON_RESET != 0) && !init_done_q;
        douta_d     = douta_q;
        sweep_cnt_d = sweep_cnt_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;
        mem_waddr   = s.addra;
        mem_wdata   = s.dina;
        if (sweeping) begin
            // Sweep owns the array; user port is ignored and douta stays at its reset value.
            mem_we      = 1'b1;
            mem_waddr   = sweep_cnt_q;
            mem_wdata   = '0;
            sweep_cnt_d = sweep_cnt_q + CNT_ONE;
            if (&sweep_cnt_q) begin
                init_done_d = 1'b1;
            end
        end else if (s.ena) begin
            if (|s.wea) begin
                mem_we  = 1'b1;
                douta_d = s.dina;
            end else begin
                douta_d = mem[s.addra];
            end
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            douta_q     <= '0;
            sweep_cnt_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            douta_q     <= douta_d;
            sweep_cnt_q <= sweep_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Array contents survive reset; only the sweep clears them.
    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign s.douta     = douta_q;
    assign s.init_done = (CLEAR_ON_RESET != 0) ? init_done_q : 1'b1;
endmodule

// File: tb/tb_icache_tag_sram.sv
// tb/tb_icache_tag_sram.sv - scoreboard bench for icache_tag_sram
module tb_icache_tag_sram;
    localparam int AW    = 8;
    localparam int DW    = 20;
    localparam int WW    = 4;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_tag_sram_if #(.ADDR_W(AW), .DATA_W(DW), .WE_W(WW)) bus();

    icache_tag_sram #(
        .ADDR_W(AW), .DATA_W(DW), .WE_W(WW), .CLEAR_ON_RESET(1)
    ) dut (
        .clka (clk),
        .rsta (rst),
        .s    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [DW:0]   exp_q [$];
    logic          issued = 1'b0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;
    int            sweep_left;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: a sweep is just a countdown; when it expires the whole array reads zero.
    task automatic op(input logic en, input logic [WW-1:0] we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ena   = en;
        bus.wea   = we;
        bus.addra = a;
        bus.dina  = d;
        issued    = 1'b1;
        if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end
        end else if (en) begin
            if (we != '0) begin
                ref_mem[a] = d;
                ref_dout   = d;
            end else begin
                ref_dout = ref_mem[a];
            end
        end
        exp_q.push_back({(sweep_left == 0), ref_dout});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst        = 1'b1;
        issued     = 1'b0;
        bus.ena    = 1'b0;
        sweep_left = DEPTH;
        ref_dout   = '0;
        #1;
        check("reset_douta", 32'(bus.douta), 32'h0);
        check("reset_init_done", 32'(bus.init_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic random_op();
        logic [WW-1:0] we;
        we = ($urandom_range(0, 2) == 0) ? WW'($urandom) : '0;
        op(1'($urandom_range(0, 1)), we, AW'($urandom), DW'($urandom));
    endtask

    task automatic sweep_and_count();
        int n;
        n = 0;
        while (bus.init_done !== 1'b1 && n < 400) begin
            random_op();
            n++;
        end
        check("sweep_cycles", 32'(n), 32'd256);
    endtask

    initial begin : monitor
        logic [DW:0] e;
        forever begin
            @(posedge clk);
            if (issued) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty got douta %h exp queued entry", bus.douta);
                end else begin
                    e = exp_q.pop_front();
                    check("douta", 32'(bus.douta), 32'(e[DW-1:0]));
                    check("init_done", 32'(bus.init_done), 32'(e[DW]));
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bus.ena   = 1'b0;
        bus.wea   = '0;
        bus.addra = '0;
        bus.dina  = '0;
        @(negedge clk);
        do_reset();
        sweep_and_count();

        op(1'b1, 4'h0, 8'h00, '0);
        op(1'b1, 4'h0, 8'h7F, '0);
        op(1'b1, 4'h0, 8'hFF, '0);

        op(1'b1, 4'hF, 8'h12, 20'h8ABCD);
        op(1'b1, 4'h0, 8'h12, '0);
        op(1'b1, 4'h0, 8'h13, '0);

        op(1'b1, 4'b0100, 8'h05, 20'hFFFFF);
        op(1'b0, 4'h0, 8'h00, '0);
        op(1'b1, 4'h0, 8'h12, '0);
        op(1'b1, 4'h0, 8'h05, '0);

        op(1'b0, 4'hF, 8'h20, 20'h12345);
        op(1'b0, 4'h0, 8'h20, '0);
        op(1'b1, 4'h0, 8'h20, '0);

        op(1'b1, 4'hF, 8'hF0, 20'h9F0F0);
        op(1'b1, 4'h0, 8'hF0, '0);
        do_reset();
        for (int i = 0; i < 100; i++) begin
            op(1'b1, 4'hF, (i % 2 == 0) ? 8'hF0 : AW'($urandom), DW'($urandom) | 20'h1);
        end
        do_reset();
        sweep_and_count();
        op(1'b1, 4'h0, 8'hF0, '0);

        for (int a = 0; a < DEPTH; a++) op(1'b1, 4'hF, AW'(a), DW'(a) | 20'h80000);
        for (int a = 0; a < DEPTH; a++) op(1'b1, 4'h0, AW'(a), '0);
        op(1'b1, 4'h0, 8'h00, '0);

        for (int i = 0; i < 300; i++) random_op();

        issued  = 1'b0;
        bus.ena = 1'b0;
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
